fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 33 +++
 rtl/ifid_skid_buffer.sv | 47 ++++
 rtl/fetch_stage.sv | 161 ++++++++++++++++
 tb/tb_fetch_stage.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the front-end pipeline (fetch, decode, hazard detection).
//   - NopInstr            : canonical bubble, addi x0, x0, 0
//   - Opcode*             : RV32I major opcodes used by decode and hazard logic
//   - fetch_state_e       : fetch FSM state encoding
//   - word_align()        : clears the byte-offset bits of an address
package fetch_stage_pkg;

    localparam logic [31:0] NopInstr = 32'h0000_0013;

    // RV32I major opcodes, instr[6:0]
    localparam logic [6:0] OpcodeOp     = 7'b0110011;
    localparam logic [6:0] OpcodeOpImm  = 7'b0010011;
    localparam logic [6:0] OpcodeLoad   = 7'b0000011;
    localparam logic [6:0] OpcodeJalr   = 7'b1100111;
    localparam logic [6:0] OpcodeJal    = 7'b1101111;
    localparam logic [6:0] OpcodeBranch = 7'b1100011;

    // StFetch : request on the bus
    // StWait  : request granted, response pending
    // StFull  : response captured in the skid buffer while decode stalls
    // StDrain : a response is still due but belongs to a flushed path
    typedef enum logic [1:0] {
        StFetch = 2'b00,
        StWait  = 2'b01,
        StFull  = 2'b10,
        StDrain = 2'b11
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifid_skid_buffer.sv
// Single-entry holding register for one fetched instruction and its PC.
// Used when a memory response arrives while decode is stalled, so the response
// is never lost and the memory interface never needs to be back-pressured.
//   clk_i    : clock
//   rst_n_i  : synchronous active-low reset, empties the buffer
//   load_i   : capture instr_i / pc_i and mark the entry valid
//   clear_i  : invalidate the entry (takes priority over load_i)
//   instr_i  : instruction to capture
//   pc_i     : PC of instr_i
//   valid_o  : entry holds an instruction
//   instr_o  : buffered instruction
//   pc_o     : buffered PC
module ifid_skid_buffer (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Generates the PC, issues one outstanding request at a time to a variable-latency
// instruction memory and presents the result to decode. Honours the hazard-unit
// stall and the EX-stage redirect; a redirect flushes IF/ID and discards any
// response still in flight for the old path.
//   clk                  : clock, all state on the rising edge
//   rst_n                : synchronous active-low reset
//   stall                : hold IF/ID contents
//   redirect_valid       : EX-stage taken branch / jump
//   redirect_pc          : redirect target, bits [1:0] ignored
//   imem_req             : fetch request
//   imem_addr            : fetch address (word aligned, zero while idle)
//   imem_gnt             : memory accepts the request this cycle
//   imem_rvalid          : response valid
//   imem_rdata           : fetched instruction
//   IFID_instruction_out : instruction to decode / hazard unit
//   IFID_pc_out          : PC of IFID_instruction_out
//   IFID_valid           : 1 = real instruction, 0 = injected NOP
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NopInstr
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IFID_instruction_out,
    output logic [31:0] IFID_pc_out,
    output logic        IFID_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic [31:0]  ifid_pc_q, ifid_pc_d;
    logic         ifid_valid_q, ifid_valid_d;

    logic         skid_load;
    logic         skid_clear;
    logic         skid_valid;
    logic [31:0]  skid_instr;
    logic [31:0]  skid_pc;

    // Byte-offset bits of the redirect target are architecturally meaningless here.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    ifid_skid_buffer u_skid (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .instr_i (imem_rdata),
        .pc_i    (pc_q),
        .valid_o (skid_valid),
        .instr_o (skid_instr),
        .pc_o    (skid_pc)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;

        if (redirect_valid) begin
            // Flush wins over stall and over any response arriving this cycle.
            pc_d         = word_align(redirect_pc);
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            skid_clear   = 1'b1;
            unique case (state_q)
                // A request granted this very cycle belongs to the old path.
                StFetch: state_d = imem_gnt ? StDrain : StFetch;
                // If the pending response shows up now it is simply dropped.
                StWait,
                StDrain: state_d = imem_rvalid ? StFetch : StDrain;
                StFull:  state_d = StFetch;
                default: state_d = StFetch;
            endcase
        end else begin
            // Unless something real is delivered below, decode sees a bubble.
            if (!stall) begin
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end
            unique case (state_q)
                StFetch: begin
                    if (imem_gnt) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (imem_rvalid) begin
                        pc_d = pc_q + 32'd4;
                        if (stall) begin
                            skid_load = 1'b1;
                            state_d   = StFull;
                        end else begin
                            ifid_instr_d = imem_rdata;
                            ifid_pc_d    = pc_q;
                            ifid_valid_d = 1'b1;
                            state_d      = StFetch;
                        end
                    end
                end
                StFull: begin
                    if (!stall) begin
                        ifid_instr_d = skid_instr;
                        ifid_pc_d    = skid_pc;
                        ifid_valid_d = skid_valid;
                        skid_clear   = 1'b1;
                        state_d      = StFetch;
                    end
                end
                StDrain: begin
                    if (imem_rvalid) begin
                        state_d = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= RESET_PC;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // Request is combinational on state so it drops immediately while in reset.
    assign imem_req  = rst_n && (state_q == StFetch);
    assign imem_addr = imem_req ? pc_q : 32'h0;

    assign IFID_instruction_out = ifid_instr_q;
    assign IFID_pc_out          = ifid_pc_q;
    assign IFID_valid           = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized traffic.
// The bench plays the instruction memory and keeps a transaction-level model of
// what the fetch stage owes decode: the next fetch address, whether a response
// is owed (and whether it belongs to a flushed path) and any instruction that
// has arrived but not yet been handed to decode.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] IFID_instruction_out;
    logic [31:0] IFID_pc_out;
    logic        IFID_valid;

    fetch_stage #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .stall                (stall),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc),
        .imem_req             (imem_req),
        .imem_addr            (imem_addr),
        .imem_gnt             (imem_gnt),
        .imem_rvalid          (imem_rvalid),
        .imem_rdata           (imem_rdata),
        .IFID_instruction_out (IFID_instruction_out),
        .IFID_pc_out          (IFID_pc_out),
        .IFID_valid           (IFID_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Memory side
    bit          mem_busy = 1'b0;
    int unsigned mem_cnt  = 0;
    logic [31:0] mem_data = '0;
    logic [31:0] data_q[$];
    int unsigned gnt_pct  = 100;
    int unsigned lat_max  = 1;
    int unsigned lat_fix  = 1;

    // Reference model
    logic [31:0] m_instr    = NOP;
    logic [31:0] m_pc       = RST_PC;
    logic        m_valid    = 1'b0;
    logic [31:0] m_fetch_pc = RST_PC;
    logic [31:0] m_req_pc   = RST_PC;
    bit          m_out      = 1'b0;
    bit          m_stale    = 1'b0;
    logic [63:0] m_held[$];

    // Values sampled just before each rising edge
    logic        s_req, s_gnt, s_rvalid, e_req;
    logic [31:0] s_addr, s_rdata, e_addr;

    task automatic tick();
        @(negedge clk);
        imem_rvalid = mem_busy && (mem_cnt == 0);
        imem_rdata  = imem_rvalid ? mem_data : $urandom();
        #1;
        imem_gnt = imem_req && !mem_busy && ($urandom_range(0, 99) < gnt_pct);
        #1;
        s_req    = imem_req;
        s_addr   = imem_addr;
        s_gnt    = imem_gnt;
        s_rvalid = imem_rvalid;
        s_rdata  = imem_rdata;
        // A request is due exactly when nothing is owed and nothing is waiting.
        e_req  = rst_n && !m_out && (m_held.size() == 0);
        e_addr = m_fetch_pc;
        n_vec++;
        if (s_req !== e_req || (e_req && s_addr !== e_addr)) begin
            n_fail++;
            $display("FAIL sb_req t=%0t got req=%b addr=%h exp req=%b addr=%h",
                     $time, s_req, s_addr, e_req, e_addr);
        end
        @(posedge clk);
        if (!rst_n) begin
            m_instr = NOP; m_pc = RST_PC; m_valid = 1'b0;
            m_fetch_pc = RST_PC; m_held.delete(); m_out = 1'b0; m_stale = 1'b0;
        end else if (redirect_valid) begin
            m_instr = NOP; m_valid = 1'b0;
            m_fetch_pc = {redirect_pc[31:2], 2'b00};
            m_held.delete();
            if (m_out && s_rvalid) m_out = 1'b0;
            else if (m_out) m_stale = 1'b1;
            if (s_req && s_gnt) begin
                m_out = 1'b1; m_stale = 1'b1;
            end
        end else begin
            if (m_out && s_rvalid) begin
                if (!m_stale) begin
                    m_held.push_back({s_rdata, m_req_pc});
                    m_fetch_pc = m_req_pc + 32'd4;
                end
                m_out = 1'b0; m_stale = 1'b0;
            end
            if (s_req && s_gnt) begin
                m_out = 1'b1; m_stale = 1'b0; m_req_pc = m_fetch_pc;
            end
            if (!stall) begin
                if (m_held.size() != 0) begin
                    {m_instr, m_pc} = m_held.pop_front();
                    m_valid = 1'b1;
                end else begin
                    m_instr = NOP; m_valid = 1'b0;
                end
            end
        end
        if (s_rvalid) mem_busy = 1'b0;
        if (s_gnt) begin
            mem_busy = 1'b1;
            mem_cnt  = (lat_fix != 0) ? lat_fix - 1 : $urandom_range(1, lat_max) - 1;
            mem_data = (data_q.size() != 0) ? data_q.pop_front() : $urandom();
        end else if (mem_busy && !s_rvalid && mem_cnt > 0) begin
            mem_cnt--;
        end
        #1;
        n_vec++;
        if ({IFID_instruction_out, IFID_pc_out, IFID_valid} !== {m_instr, m_pc, m_valid}) begin
            n_fail++;
            $display("FAIL sb_ifid t=%0t got %h/%h/%b exp %h/%h/%b", $time,
                     IFID_instruction_out, IFID_pc_out, IFID_valid, m_instr, m_pc, m_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_vec++;
        if (imem_req !== 1'b0 ||
            {IFID_instruction_out, IFID_pc_out, IFID_valid} !== {NOP, RST_PC, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state got req=%b %h/%h/%b exp req=0 %h/%h/0", imem_req,
                     IFID_instruction_out, IFID_pc_out, IFID_valid, NOP, RST_PC);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        gnt_pct = 100;
        lat_fix = 1;
        data_q.push_back(32'h0050_0093);
        data_q.push_back(32'h00A0_0113);
        tick();
        n_vec++;
        if (s_req !== 1'b1 || s_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL basic_addr0 got req=%b addr=%h exp req=1 addr=0", s_req, s_addr);
        end
        tick();
        n_vec++;
        if ({IFID_instruction_out, IFID_pc_out, IFID_valid} !== {32'h0050_0093, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_ifid0 got %h/%h/%b exp 00500093/00000000/1",
                     IFID_instruction_out, IFID_pc_out, IFID_valid);
        end
        tick();
        n_vec++;
        if (s_req !== 1'b1 || s_addr !== 32'h4) begin
            n_fail++;
            $display("FAIL basic_addr4 got req=%b addr=%h exp req=1 addr=4", s_req, s_addr);
        end
        tick();
        n_vec++;
        if ({IFID_instruction_out, IFID_pc_out, IFID_valid} !== {32'h00A0_0113, 32'h4, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_ifid1 got %h/%h/%b exp 00a00113/00000004/1",
                     IFID_instruction_out, IFID_pc_out, IFID_valid);
        end
    endtask

    task automatic test_stall();
        data_q.push_back(32'h0020_81B3);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ((i > 0 && s_req !== 1'b0) ||
                {IFID_instruction_out, IFID_pc_out, IFID_valid} !==
                {32'h00A0_0113, 32'h4, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_hold cyc=%0d got req=%b %h/%h/%b exp held 00a00113/4/1",
                         i, s_req, IFID_instruction_out, IFID_pc_out, IFID_valid);
            end
        end
        stall = 1'b0;
        tick();
        n_vec++;
        if ({IFID_instruction_out, IFID_pc_out, IFID_valid} !== {32'h0020_81B3, 32'h8, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_release got %h/%h/%b exp 002081b3/00000008/1",
                     IFID_instruction_out, IFID_pc_out, IFID_valid);
        end
    endtask

    task automatic test_redirect();
        bit found = 1'b0;
        lat_fix = 3;
        data_q.push_back(32'hDEAD_BEEF);
        tick();
        n_vec++;
        if (s_req !== 1'b1 || s_addr !== 32'hC) begin
            n_fail++;
            $display("FAIL redir_addrC got req=%b addr=%h exp req=1 addr=c", s_req, s_addr);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        n_vec++;
        if (IFID_instruction_out !== NOP || IFID_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_flush got %h/%b exp %h/0", IFID_instruction_out, IFID_valid, NOP);
        end
        lat_fix = 1;
        data_q.push_back(32'h0010_0093);
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            n_vec++;
            if (IFID_instruction_out === 32'hDEAD_BEEF) begin
                n_fail++;
                $display("FAIL redir_stale got %h exp any but deadbeef", IFID_instruction_out);
            end
            if (s_req) begin
                found = 1'b1;
                n_vec++;
                if (s_addr !== 32'h100) begin
                    n_fail++;
                    $display("FAIL redir_target got addr=%h exp 00000100", s_addr);
                end
            end
        end
        if (!found) begin
            n_fail++;
            $display("FAIL redir_timeout got no request exp request to 00000100");
        end
    endtask

    task automatic test_flush_priority();
        bit found = 1'b0;
        data_q.push_back(32'h1234_5678);
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = s_req && s_gnt;
        end
        if (!found) begin
            n_fail++;
            $display("FAIL flush_setup_timeout got no grant exp grant");
        end
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        n_vec++;
        if (IFID_instruction_out !== NOP || IFID_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_prio got %h/%b exp %h/0", IFID_instruction_out, IFID_valid, NOP);
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            n_vec++;
            if (IFID_instruction_out === 32'h1234_5678) begin
                n_fail++;
                $display("FAIL flush_drop got %h exp any but 12345678", IFID_instruction_out);
            end
            if (s_req) begin
                found = 1'b1;
                n_vec++;
                if (s_addr !== 32'h200) begin
                    n_fail++;
                    $display("FAIL flush_target got addr=%h exp 00000200", s_addr);
                end
            end
        end
        if (!found) begin
            n_fail++;
            $display("FAIL flush_timeout got no request exp request to 00000200");
        end
    endtask

    task automatic test_wrap();
        bit found = 1'b0;
        bit found0 = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        data_q.push_back(32'h0000_0493);
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (s_req) begin
                found = 1'b1;
                n_vec++;
                if (s_addr !== 32'hFFFF_FFFC) begin
                    n_fail++;
                    $display("FAIL wrap_target got addr=%h exp fffffffc", s_addr);
                end
            end
        end
        for (int i = 0; i < 20 && !found0; i++) begin
            tick();
            if (s_req) begin
                found0 = 1'b1;
                n_vec++;
                if (s_addr !== 32'h0) begin
                    n_fail++;
                    $display("FAIL wrap_next got addr=%h exp 00000000", s_addr);
                end
            end
        end
        if (!found || !found0) begin
            n_fail++;
            $display("FAIL wrap_timeout got no request exp requests to fffffffc then 0");
        end
    endtask

    task automatic test_reset_mid_wait();
        bit first = 1'b1;
        bit done  = 1'b0;
        tick();
        lat_fix = 3;
        data_q.push_back(32'hCAFE_F00D);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        n_vec++;
        if (imem_req !== 1'b0 ||
            {IFID_instruction_out, IFID_pc_out, IFID_valid} !== {NOP, RST_PC, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid got req=%b %h/%h/%b exp req=0 %h/%h/0", imem_req,
                     IFID_instruction_out, IFID_pc_out, IFID_valid, NOP, RST_PC);
        end
        rst_n   = 1'b1;
        lat_fix = 1;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            n_vec++;
            if (IFID_instruction_out === 32'hCAFE_F00D || IFID_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_late_rvalid got %h/%b exp %h/0",
                         IFID_instruction_out, IFID_valid, NOP);
            end
            if (s_req && first) begin
                first = 1'b0;
                n_vec++;
                if (s_addr !== RST_PC) begin
                    n_fail++;
                    $display("FAIL rst_first_addr got %h exp %h", s_addr, RST_PC);
                end
            end
            done = s_req && s_gnt;
        end
        if (!done) begin
            n_fail++;
            $display("FAIL rst_timeout got no grant exp grant after reset");
        end
    endtask

    task automatic test_random();
        lat_fix = 0;
        lat_max = 4;
        gnt_pct = 60;
        for (int i = 0; i < 3000; i++) begin
            stall          = ($urandom_range(0, 99) < 30);
            redirect_valid = ($urandom_range(0, 99) < 6);
            redirect_pc    = $urandom();
            rst_n          = ($urandom_range(0, 199) != 0);
            tick();
        end
        stall          = 1'b0;
        redirect_valid = 1'b0;
        rst_n          = 1'b1;
        for (int i = 0; i < 10; i++) tick();
    endtask

    initial begin
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_flush_priority();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no end of run exp end before 1000000");
        $fatal(1, "watchdog expired");
    end

endmodule
